uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_frame

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx_framer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framer: FSM state encoding and default bit period.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: 8N1 (or 8E1 when UART_RX_PARITY_EN is defined) with a one-byte
// holding register, valid/ready handoff and frame/overrun/parity error pulses.
module uart_rx_framer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic             w_rxs;
   rx_state_t        r_state;
   logic [CNT_W-1:0] r_baud;
   logic [2:0]       r_bitcnt;
   logic [7:0]       r_shift;
   logic             r_done;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_frame_err;
   logic             r_overrun;
`ifdef UART_RX_PARITY_EN
   logic             r_par_bad;
   logic             r_parity_err;
`endif

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rxd),
      .o_q   (w_rxs)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_baud      <= '0;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_done      <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif

         // A completed byte lands one edge after its stop sample; an accept on that
         // same edge frees the holding register so the new byte is not an overrun.
         if (r_done) begin
            if (!r_rx_valid || rx_ready) begin
               r_rx_data  <= r_shift;
               r_rx_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end

         r_baud <= r_baud + CNT_W'(1);
         case (r_state)
            ST_IDLE: begin
               r_baud <= '0;
               if (!w_rxs) r_state <= ST_START;
            end
            ST_START: begin
               if (r_baud == HALF_LAST) begin
                  r_baud  <= '0;
                  r_state <= w_rxs ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (r_baud == BIT_LAST) begin
                  r_baud   <= '0;
                  r_shift  <= {w_rxs, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (r_baud == BIT_LAST) begin
                  r_baud       <= '0;
                  r_state      <= ST_STOP;
                  r_par_bad    <= (w_rxs != ^r_shift);
                  r_parity_err <= (w_rxs != ^r_shift);
               end
            end
`endif
            ST_STOP: begin
               if (r_baud == BIT_LAST) begin
                  r_baud <= '0;
                  if (!w_rxs) begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_WAIT_IDLE;
                  end else begin
                     r_state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                     r_done  <= !r_par_bad;
`else
                     r_done  <= 1'b1;
`endif
                  end
               end
            end
            ST_WAIT_IDLE: begin
               r_baud <= '0;
               if (w_rxs) r_state <= ST_IDLE;
            end
            default: begin
               r_baud  <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule
